bgr_startup_ctrl: RTL

- Digital start-up sequencer directly upstream of bgr_top.
- Drives the bandgap `porst` kick transistor (M10), waits for the loop to settle, and checks a synchronised comparator flag that says vbg is in window.
- Retries the kick a bounded number of times, then raises `bgr_ready` to downstream consumers (ADC/LDO enables), or raises `bgr_fault`.
- Keeps monitoring vbg after READY and re-kicks if it collapses.

---
 rtl/bgr_startup_ctrl_if.sv | 36 +++
 rtl/bgr_startup_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bgr_startup_ctrl_if.sv
// ---------------------------------------------------------------------------
// bgr_startup_ctrl_if
// Bundles the bandgap start-up sequencer's control and status signals.
//   enable    : request to bring up the bandgap (system -> sequencer)
//   vbg_ok    : asynchronous comparator flag, 1 = vbg in window
//   porst     : start-up kick to bgr_top, active high
//   bgr_ready : vbg valid and filtered
//   bgr_fault : start-up failed, sticky until enable drops
// Modports:
//   master : the system side (drives enable, observes outputs; the comparator
//            output vbg_ok is delivered through the same side)
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface bgr_startup_ctrl_if;
    logic enable;
    logic vbg_ok;
    logic porst;
    logic bgr_ready;
    logic bgr_fault;

    modport master (
        output enable,
        output vbg_ok,
        input  porst,
        input  bgr_ready,
        input  bgr_fault
    );

    modport slave (
        input  enable,
        input  vbg_ok,
        output porst,
        output bgr_ready,
        output bgr_fault
    );
endinterface

// File: rtl/bgr_startup_ctrl.sv
// ---------------------------------------------------------------------------
// bgr_startup_ctrl
// Start-up sequencer for the bandgap: pulses porst, waits for the loop to
// settle, checks a filtered vbg_ok, retries a bounded number of times and then
// reports ready or fault. After ready it keeps watching vbg and re-kicks if
// the reference collapses.
//
// Ports:
//   clk  : sequencer clock
//   rst  : asynchronous active-high reset
//   bus  : bgr_startup_ctrl_if.slave (enable, vbg_ok in; porst, bgr_ready,
//          bgr_fault out, all outputs registered)
//
// Optional build macro BGR_STARTUP_STATUS_EN adds:
//   status_state [2:0] : IDLE=0 KICK=1 SETTLE=2 CHECK=3 READY=4 FAULT=5
//   status_fails [2:0] : current failed-window count
//   kick_total   [7:0] : saturating count of kicks since reset
// ---------------------------------------------------------------------------
module bgr_startup_ctrl #(
    parameter int CNT_W         = 12,
    parameter int PULSE_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 1024,
    parameter int CHECK_CYCLES  = 64,
    parameter int OK_FILT       = 8,
    parameter int MAX_RETRY     = 3
) (
    input  logic              clk,
    input  logic              rst,
    bgr_startup_ctrl_if.slave bus
`ifdef BGR_STARTUP_STATUS_EN
    ,
    output logic [2:0]        status_state,
    output logic [2:0]        status_fails,
    output logic [7:0]        kick_total
`endif
);

    localparam int RUN_W = $clog2(OK_FILT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_KICK   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_READY  = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    logic [2:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [RUN_W-1:0] run, run_n, run_inc;
    logic [2:0]       fails, fails_n;
    logic             vbg_meta, vbg_s;
    logic             porst_q, ready_q, fault_q;

    // Two-flop synchroniser for the asynchronous comparator flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vbg_meta <= 1'b0;
            vbg_s    <= 1'b0;
        end else begin
            vbg_meta <= bus.vbg_ok;
            vbg_s    <= vbg_meta;
        end
    end

    assign run_inc = (run == RUN_W'(OK_FILT)) ? run : run + RUN_W'(1);

    always_comb begin
        state_n = state;
        cnt_n   = '0;
        run_n   = run;
        fails_n = fails;

        case (state)
            S_IDLE: begin
                fails_n = '0;
                run_n   = '0;
                if (bus.enable) begin
                    state_n = S_KICK;
                end
            end

            S_KICK: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
                    state_n = S_SETTLE;
                    cnt_n   = '0;
                end
            end

            S_SETTLE: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_n = S_CHECK;
                    cnt_n   = '0;
                    run_n   = '0;
                end
            end

            S_CHECK: begin
                cnt_n = cnt + CNT_W'(1);
                run_n = vbg_s ? run_inc : '0;
                // Success is tested first so it beats a simultaneous timeout.
                if (run_n == RUN_W'(OK_FILT)) begin
                    state_n = S_READY;
                    cnt_n   = '0;
                    run_n   = '0;
                    fails_n = '0;
                end else if (cnt == CNT_W'(CHECK_CYCLES - 1)) begin
                    cnt_n   = '0;
                    fails_n = fails + 3'd1;
                    state_n = (fails_n == 3'(MAX_RETRY)) ? S_FAULT : S_KICK;
                end
            end

            S_READY: begin
                run_n = vbg_s ? '0 : run_inc;
                if (run_n == RUN_W'(OK_FILT)) begin
                    state_n = S_KICK;
                    run_n   = '0;
                    fails_n = '0;
                end
            end

            S_FAULT: begin
                state_n = S_FAULT;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Dropping enable wins over every other transition.
        if (!bus.enable) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            run_n   = '0;
            fails_n = '0;
        end
    end

    // Outputs are registered decodes of the next state so they line up with
    // the state register and never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            run     <= '0;
            fails   <= '0;
            porst_q <= 1'b0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            run     <= run_n;
            fails   <= fails_n;
            porst_q <= (state_n == S_KICK);
            ready_q <= (state_n == S_READY);
            fault_q <= (state_n == S_FAULT);
        end
    end

    assign bus.porst     = porst_q;
    assign bus.bgr_ready = ready_q;
    assign bus.bgr_fault = fault_q;

`ifdef BGR_STARTUP_STATUS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kick_total <= '0;
        end else if (state_n == S_KICK && state != S_KICK && kick_total != '1) begin
            kick_total <= kick_total + 8'd1;
        end
    end

    assign status_state = state;
    assign status_fails = fails;
`endif

endmodule
